// File: rtl/udc_pkg.sv
// Shared constants and types for the up/down-counter job sequencer.
// Register addresses follow the counter's {a1,a0} map.
package udc_pkg;

    localparam logic [1:0] ADDR_PLR = 2'd0;
    localparam logic [1:0] ADDR_ULR = 2'd1;
    localparam logic [1:0] ADDR_LLR = 2'd2;
    localparam logic [1:0] ADDR_CCR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PLR,
        ST_WR_ULR,
        ST_WR_LLR,
        ST_WR_CCR,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_ERR     = 2'b01,
        STAT_TIMEOUT = 2'b10,
        STAT_ABORTED = 2'b11
    } status_t;

endpackage

// File: rtl/udc_watchdog.sv
// RUN-cycle counter: cleared on RUN entry, counts up while enabled and
// saturates at TIMEOUT. `first` marks the cycle right after a clear.
module udc_watchdog #(
    parameter int TIMEOUT = 1023,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] value,
    output logic         first,
    output logic         terminal
);

    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (enable && (value != LIMIT)) begin
            value <= value + 1'b1;
        end
    end

    assign first    = (value == '0);
    assign terminal = (value == LIMIT);

endmodule

// File: rtl/udc_job_sequencer.sv
// Host-side job sequencer: programs the up/down counter over its bus,
// starts it, supervises the run and returns a one-cycle status response.
module udc_job_sequencer
    import udc_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_plr,
    input  logic [7:0] job_ulr,
    input  logic [7:0] job_llr,
    input  logic [7:0] job_ccr,
    input  logic       abort,
    output logic       resp_valid,
    output logic [1:0] resp_status,
    output logic [7:0] resp_count,
    output logic       resp_dir,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       start,
    output logic       a0,
    output logic       a1,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic       err,
    input  logic       ec,
    input  logic       dir,
    input  logic [7:0] count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t     state, state_next;
    status_t    status_next;
    logic       term;

    logic [7:0] plr_q, ulr_q, llr_q, ccr_q;

    logic            wd_clear, wd_enable, wd_first, wd_terminal;
    logic [WD_W-1:0] wd_value;

    logic       ncs_d, nwr_d, start_d, oe_d;
    logic [1:0] addr_d, addr_q;
    logic [7:0] dout_d;

    udc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .value    (wd_value),
        .first    (wd_first),
        .terminal (wd_terminal)
    );

    assign wd_clear  = (state_next == ST_RUN) && (state != ST_RUN);
    assign wd_enable = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // err/ec in the first RUN cycle still reflect the previous run.
    always_comb begin
        state_next  = state;
        status_next = STAT_OK;
        term        = 1'b0;
        case (state)
            ST_IDLE:   if (job_valid) state_next = ST_WR_PLR;
            ST_WR_PLR: state_next = ST_WR_ULR;
            ST_WR_ULR: state_next = ST_WR_LLR;
            ST_WR_LLR: state_next = ST_WR_CCR;
            ST_WR_CCR: state_next = ST_START;
            ST_START:  state_next = ST_RUN;
            ST_RUN: begin
                if (!wd_first && err) begin
                    term        = 1'b1;
                    status_next = STAT_ERR;
                end else if (!wd_first && ec) begin
                    term        = 1'b1;
                    status_next = STAT_OK;
                end else if (abort) begin
                    term        = 1'b1;
                    status_next = STAT_ABORTED;
                end else if (wd_terminal) begin
                    term        = 1'b1;
                    status_next = STAT_TIMEOUT;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if ((state inside {ST_WR_PLR, ST_WR_ULR, ST_WR_LLR, ST_WR_CCR, ST_START}) && abort) begin
            term        = 1'b1;
            status_next = STAT_ABORTED;
        end
        if (term) state_next = ST_DONE;
    end

    // Bus levels are decoded from the next state so the registered strobes
    // line up with the state they belong to.
    always_comb begin
        ncs_d   = 1'b1;
        nwr_d   = 1'b1;
        start_d = 1'b0;
        oe_d    = 1'b0;
        addr_d  = 2'd0;
        dout_d  = 8'd0;
        case (state_next)
            ST_WR_PLR: begin
                ncs_d = 1'b0; nwr_d = 1'b0; oe_d = 1'b1;
                addr_d = ADDR_PLR; dout_d = job_plr;
            end
            ST_WR_ULR: begin
                ncs_d = 1'b0; nwr_d = 1'b0; oe_d = 1'b1;
                addr_d = ADDR_ULR; dout_d = ulr_q;
            end
            ST_WR_LLR: begin
                ncs_d = 1'b0; nwr_d = 1'b0; oe_d = 1'b1;
                addr_d = ADDR_LLR; dout_d = llr_q;
            end
            ST_WR_CCR: begin
                ncs_d = 1'b0; nwr_d = 1'b0; oe_d = 1'b1;
                addr_d = ADDR_CCR; dout_d = ccr_q;
            end
            ST_START: begin
                ncs_d = 1'b0; start_d = 1'b1;
            end
            ST_RUN:   ncs_d = 1'b0;
            default:  ncs_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plr_q <= 8'd0;
            ulr_q <= 8'd0;
            llr_q <= 8'd0;
            ccr_q <= 8'd0;
        end else if (job_valid && job_ready) begin
            plr_q <= job_plr;
            ulr_q <= job_ulr;
            llr_q <= job_llr;
            ccr_q <= job_ccr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ncs         <= 1'b1;
            nwr         <= 1'b1;
            start       <= 1'b0;
            bus_oe      <= 1'b0;
            addr_q      <= 2'd0;
            bus_dout    <= 8'd0;
            resp_valid  <= 1'b0;
            resp_status <= 2'b00;
            resp_count  <= 8'd0;
            resp_dir    <= 1'b0;
        end else begin
            ncs        <= ncs_d;
            nwr        <= nwr_d;
            start      <= start_d;
            bus_oe     <= oe_d;
            addr_q     <= addr_d;
            bus_dout   <= dout_d;
            resp_valid <= term;
            if (term) begin
                resp_status <= status_next;
                resp_count  <= count;
                resp_dir    <= dir;
            end
        end
    end

    assign a0        = addr_q[0];
    assign a1        = addr_q[1];
    assign nrd       = 1'b1;
    assign job_ready = (state == ST_IDLE);

    logic unused_plr;
    assign unused_plr = ^{plr_q, wd_value};

endmodule

// File: tb/tb_udc_job_sequencer.sv
// Directed bench for udc_job_sequencer; the bench itself plays the counter
// by driving err/ec/dir/count by hand.
module tb_udc_job_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       job_valid = 1'b0;
    logic       job_ready;
    logic [7:0] job_plr = 8'd0, job_ulr = 8'd0, job_llr = 8'd0, job_ccr = 8'd0;
    logic       abort = 1'b0;
    logic       resp_valid;
    logic [1:0] resp_status;
    logic [7:0] resp_count;
    logic       resp_dir;
    logic       ncs, nwr, nrd, start, a0, a1, bus_oe;
    logic [7:0] bus_dout;
    logic       err = 1'b0, ec = 1'b0, dir = 1'b0;
    logic [7:0] count = 8'd0;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] IDLE_V  = 7'b1110000;
    localparam logic [6:0] START_V = 7'b0110001;
    localparam logic [6:0] RUN_V   = 7'b0110000;

    udc_job_sequencer #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_plr(job_plr), .job_ulr(job_ulr), .job_llr(job_llr), .job_ccr(job_ccr),
        .abort(abort),
        .resp_valid(resp_valid), .resp_status(resp_status),
        .resp_count(resp_count), .resp_dir(resp_dir),
        .ncs(ncs), .nwr(nwr), .nrd(nrd), .start(start), .a0(a0), .a1(a1),
        .bus_dout(bus_dout), .bus_oe(bus_oe),
        .err(err), .ec(ec), .dir(dir), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] busv();
        return {ncs, nwr, nrd, bus_oe, a1, a0, start};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a job in an IDLE cycle, check the four writes, return in START.
    task automatic issue(input logic [7:0] p, u, l, c, input logic hold,
                         input logic [7:0] np, nu, nl, nc);
        logic [7:0] d [4];
        logic [1:0] a;
        d[0] = p; d[1] = u; d[2] = l; d[3] = c;
        job_plr = p; job_ulr = u; job_llr = l; job_ccr = c;
        job_valid = 1'b1;
        chk("ready_idle", {31'd0, job_ready}, 32'd1);
        tick();
        job_valid = hold;
        job_plr = np; job_ulr = nu; job_llr = nl; job_ccr = nc;
        for (int i = 0; i < 4; i++) begin
            a = i[1:0];
            chk("wr_bus", {25'd0, busv()}, {25'd0, 4'b0011, a, 1'b0});
            chk("wr_data", {24'd0, bus_dout}, {24'd0, d[i]});
            tick();
        end
        chk("start_bus", {25'd0, busv()}, {25'd0, START_V});
        chk("ready_busy", {31'd0, job_ready}, 32'd0);
    endtask

    initial begin
        // reset values
        tick(); tick();
        chk("rst_bus", {25'd0, busv()}, {25'd0, IDLE_V});
        chk("rst_dout", {24'd0, bus_dout}, 32'd0);
        chk("rst_ready", {31'd0, job_ready}, 32'd1);
        chk("rst_resp", {20'd0, resp_valid, resp_status, resp_count, resp_dir}, 32'd0);
        reset = 1'b1;

        // basic job, inputs scrambled after acceptance
        issue(8'd10, 8'd15, 8'd5, 8'd2, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        tick();
        chk("run_bus", {25'd0, busv()}, {25'd0, RUN_V});
        count = 8'd12;
        tick();
        chk("basic_wait", {31'd0, resp_valid}, 32'd0);
        ec = 1'b1; count = 8'd15; dir = 1'b1;
        tick();
        chk("basic_valid", {31'd0, resp_valid}, 32'd1);
        chk("basic_status", {30'd0, resp_status}, 32'd0);
        chk("basic_count", {24'd0, resp_count}, 32'd15);
        chk("basic_dir", {31'd0, resp_dir}, 32'd1);
        chk("done_bus", {25'd0, busv()}, {25'd0, IDLE_V});
        chk("done_ready", {31'd0, job_ready}, 32'd0);
        ec = 1'b0; count = 8'd0; dir = 1'b0;
        tick();
        chk("basic_strobe", {31'd0, resp_valid}, 32'd0);
        chk("basic_ready", {31'd0, job_ready}, 32'd1);

        // error, err and ec together; first RUN cycle ignored
        issue(8'd5, 8'd5, 8'd7, 8'd3, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        err = 1'b1; ec = 1'b1; count = 8'd5; dir = 1'b0;
        tick();
        chk("err_first_ignored", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("err_valid", {31'd0, resp_valid}, 32'd1);
        chk("err_status", {30'd0, resp_status}, 32'd1);
        chk("err_count", {24'd0, resp_count}, 32'd5);
        err = 1'b0; ec = 1'b0;
        tick();

        // timeout: valid 9 cycles after RUN entry
        issue(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        count = 8'h42; dir = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_wait", {31'd0, resp_valid}, 32'd0);
        end
        tick();
        chk("to_valid", {31'd0, resp_valid}, 32'd1);
        chk("to_status", {30'd0, resp_status}, 32'd2);
        chk("to_count", {24'd0, resp_count}, 32'h42);
        chk("to_dir", {31'd0, resp_dir}, 32'd1);
        count = 8'd0; dir = 1'b0;
        tick();

        // stale ec, then reset mid-RUN
        issue(8'd7, 8'd9, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        ec = 1'b1;
        tick();
        tick();
        chk("stale_ec", {31'd0, resp_valid}, 32'd0);
        ec = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_bus", {25'd0, busv()}, {25'd0, IDLE_V});
        chk("arst_ready", {31'd0, job_ready}, 32'd1);
        chk("arst_resp", {20'd0, resp_valid, resp_status, resp_count, resp_dir}, 32'd0);
        tick();
        chk("arst_novalid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b1;

        // job right after release, aborted in WR_LLR
        job_plr = 8'h21; job_ulr = 8'h22; job_llr = 8'h23; job_ccr = 8'h24;
        job_valid = 1'b1; count = 8'h5A;
        tick();
        chk("post_rst_accept", {25'd0, busv()}, {25'd0, 7'b0011000});
        chk("post_rst_data", {24'd0, bus_dout}, 32'h21);
        job_valid = 1'b0;
        tick();
        chk("ab_ulr", {24'd0, bus_dout}, 32'h22);
        tick();
        chk("ab_llr_bus", {25'd0, busv()}, {25'd0, 7'b0011100});
        abort = 1'b1;
        tick();
        chk("ab_done_bus", {25'd0, busv()}, {25'd0, IDLE_V});
        chk("ab_valid", {31'd0, resp_valid}, 32'd1);
        chk("ab_status", {30'd0, resp_status}, 32'd3);
        chk("ab_count", {24'd0, resp_count}, 32'h5A);
        tick();
        chk("ab_idle_ready", {31'd0, job_ready}, 32'd1);
        chk("ab_idle_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("ab_idle_hold", {25'd0, busv()}, {25'd0, IDLE_V});
        abort = 1'b0;

        // back-to-back with job_valid held; first run aborted in RUN
        count = 8'h10;
        issue(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        tick();
        tick();
        abort = 1'b1;
        tick();
        chk("run_ab_valid", {31'd0, resp_valid}, 32'd1);
        chk("run_ab_status", {30'd0, resp_status}, 32'd3);
        chk("run_ab_count", {24'd0, resp_count}, 32'h10);
        abort = 1'b0;
        tick();
        issue(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        tick();
        tick();
        ec = 1'b1; count = 8'h77;
        tick();
        chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_status", {30'd0, resp_status}, 32'd0);
        chk("b2b_count", {24'd0, resp_count}, 32'h77);
        ec = 1'b0;
        tick();
        chk("b2b_ready", {31'd0, job_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
